// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial engine, its requester and scoreboards:
// default widths, the requester FSM state type and the golden factorial model.
package factorial_pkg;

  localparam int unsigned DefInDataWd  = 3;
  localparam int unsigned DefOutDataWd = 16;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCheck,
    StDone
  } state_e;

  // n! modulo 2^64; callers truncate to their own result width.
  function automatic logic [63:0] golden_fact(input int unsigned n);
    logic [63:0] f;
    f = 64'd1;
    for (int unsigned i = 2; i <= n; i++) begin
      f = f * 64'(i);
    end
    return f;
  endfunction

endpackage

// File: rtl/factorial_req_timer.sv
// Response-wait cycle counter: cleared outside WAIT, counts while enabled and
// flags expire once it reaches TIMEOUT_CYC-1.
module factorial_req_timer #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntWd = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntWd-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == CntWd'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/factorial_requester.sv
// Self-test initiator for the factorial engine: sweeps every operand once,
// one request in flight, and scores each result against the golden table.
module factorial_requester
  import factorial_pkg::*;
#(
  parameter int unsigned IN_DATA_WD  = DefInDataWd,
  parameter int unsigned OUT_DATA_WD = DefOutDataWd,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [IN_DATA_WD-1:0]  in_data,
  output logic                   in_valid,
  input  logic [OUT_DATA_WD-1:0] out_data,
  input  logic                   out_valid,
  input  logic                   out_busy,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [IN_DATA_WD:0]    err_count,
  output logic [IN_DATA_WD-1:0]  first_err_op,
  output logic                   timeout_seen,
  output logic [3:0]             spurious_cnt
);

  localparam int unsigned NumOps = 2 ** IN_DATA_WD;
  localparam int unsigned OpWd   = IN_DATA_WD + 1;
  localparam logic [OpWd-1:0] LastOp = OpWd'(NumOps - 1);

  state_e state_q, state_d;

  logic [OpWd-1:0]        op_q, op_d;
  logic [OUT_DATA_WD-1:0] res_q, res_d;
  logic [IN_DATA_WD:0]    err_q, err_d;
  logic [IN_DATA_WD-1:0]  first_q, first_d;
  logic                   tmo_q, tmo_d;
  logic [3:0]             spur_q, spur_d;
  logic                   pass_q, pass_d;

  logic expire, timeout, mismatch, advance, is_last, start_ok;
  logic [OUT_DATA_WD-1:0] golden_tbl [NumOps];

  for (genvar g = 0; g < NumOps; g++) begin : g_golden
    assign golden_tbl[g] = OUT_DATA_WD'(golden_fact(g));
  end

  factorial_req_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != StWait),
    .enable (state_q == StWait),
    .expire (expire)
  );

  assign is_last  = (op_q == LastOp);
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  assign timeout  = (state_q == StWait) && !out_valid && expire;
  assign mismatch = (state_q == StCheck) && (res_q != golden_tbl[op_q[IN_DATA_WD-1:0]]);
  assign advance  = timeout || (state_q == StCheck);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StIssue;
      StIssue:        if (!out_busy) state_d = StWait;
      StWait: begin
        if (out_valid) begin
          state_d = StCheck;
        end else if (expire) begin
          state_d = is_last ? StDone : StIssue;
        end
      end
      StCheck:        state_d = is_last ? StDone : StIssue;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    in_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIssue: begin
        in_valid = !out_busy;
        busy     = 1'b1;
      end
      StWait, StCheck: busy = 1'b1;
      StDone:          done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    first_d = first_q;
    tmo_d   = tmo_q;
    spur_d  = spur_q;
    pass_d  = pass_q;
    if (state_q == StWait && out_valid) begin
      res_d = out_data;
    end
    if (out_valid && state_q != StWait && spur_q != 4'hf) begin
      spur_d = spur_q + 4'd1;
    end
    if (timeout || mismatch) begin
      err_d = (err_q == '1) ? err_q : err_q + 1'b1;
      if (err_q == '0) first_d = op_q[IN_DATA_WD-1:0];
      if (timeout) tmo_d = 1'b1;
    end
    if (advance) begin
      if (is_last) begin
        // Sampled on the way into DONE so the final operand's verdict is included.
        pass_d = (err_d == '0) && (spur_d == '0);
      end else begin
        op_d = op_q + 1'b1;
      end
    end
    if (start_ok) begin
      op_d    = '0;
      err_d   = '0;
      first_d = '0;
      tmo_d   = 1'b0;
      spur_d  = '0;
      pass_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      tmo_q   <= 1'b0;
      spur_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      first_q <= first_d;
      tmo_q   <= tmo_d;
      spur_q  <= spur_d;
      pass_q  <= pass_d;
    end
  end

  assign in_data      = op_q[IN_DATA_WD-1:0];
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign first_err_op = first_q;
  assign timeout_seen = tmo_q;
  assign spurious_cnt = spur_q;

endmodule

// File: tb/tb_factorial_requester.sv
// Bench for factorial_requester: a scripted engine model answers requests while
// a scoreboard checks the operand order and the final status of each sweep.
module tb_factorial_requester;

  localparam int unsigned InW  = 3;
  localparam int unsigned OutW = 16;
  localparam int unsigned Tmo  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            out_valid = 1'b0;
  logic            out_busy = 1'b0;
  logic [OutW-1:0] out_data = '0;
  logic [InW-1:0]  in_data;
  logic            in_valid, busy, done, pass, timeout_seen;
  logic [InW:0]    err_count;
  logic [InW-1:0]  first_err_op;
  logic [3:0]      spurious_cnt;

  factorial_requester #(
    .IN_DATA_WD  (InW),
    .OUT_DATA_WD (OutW),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_busy     (out_busy),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_err_op (first_err_op),
    .timeout_seen (timeout_seen),
    .spurious_cnt (spurious_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pass_v;
    int err;
    int first;
    int tmo;
    int spur;
  } status_t;

  int      n_cmp = 0;
  int      n_bad = 0;
  int      exp_ops[$];
  status_t exp_st[$];
  int      gold[8] = '{1, 1, 2, 6, 24, 120, 720, 5040};
  int      req_cyc[8];
  int      cyc = 0;
  int      last_req_op = -1;

  // Engine model knobs
  int lat = 3;
  int bad_op = -1;
  int bad_val = 0;
  int drop_op = -1;
  int busy_op = -1;
  int busy_len = 0;
  int spur_at = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  // Engine: answers lat cycles after a request, with optional corruption, drop,
  // a busy window before busy_op and one unsolicited strobe inside that window.
  initial begin : engine
    int   cnt;
    int   resp;
    int   resp_op;
    int   busy_left;
    logic req_seen;
    int   req_op;
    cnt = -1;
    resp = 0;
    resp_op = -1;
    busy_left = 0;
    forever begin
      @(negedge clk);
      req_seen = in_valid;
      req_op   = int'(in_data);
      @(posedge clk);
      #1;
      out_valid = 1'b0;
      out_busy  = 1'b0;
      if (busy_left > 0) begin
        out_busy = 1'b1;
        if (busy_len - busy_left == spur_at) begin
          out_valid = 1'b1;
          out_data  = 16'hdead;
        end
        busy_left--;
      end
      if (cnt == 0) begin
        out_valid = 1'b1;
        out_data  = OutW'(resp);
        cnt = -1;
        if (resp_op == busy_op - 1) busy_left = busy_len;
      end else if (cnt > 0) begin
        cnt--;
      end
      if (req_seen && req_op != drop_op) begin
        cnt     = lat - 2;
        resp    = (req_op == bad_op) ? bad_val : gold[req_op];
        resp_op = req_op;
      end
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    logic    done_prev;
    logic    busy_prev;
    status_t s;
    done_prev = 1'b0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (in_valid) begin
        if (exp_ops.size() == 0) check("spare_req_op", int'(in_data), -1);
        else check("req_op", int'(in_data), exp_ops.pop_front());
        last_req_op = int'(in_data);
        req_cyc[in_data] = cyc;
      end
      if (out_busy) check("busy_hold_in_valid", int'(in_valid), 0);
      else if (busy_prev) check("issue_after_busy", int'(in_valid), 1);
      busy_prev = out_busy;
      if (done && !done_prev) begin
        if (exp_st.size() == 0) begin
          check("spare_done", int'(done), 0);
        end else begin
          s = exp_st.pop_front();
          check("pass", int'(pass), s.pass_v);
          check("err_count", int'(err_count), s.err);
          check("first_err_op", int'(first_err_op), s.first);
          check("timeout_seen", int'(timeout_seen), s.tmo);
          check("spurious_cnt", int'(spurious_cnt), s.spur);
          check("ops_left", exp_ops.size(), 0);
        end
      end
      done_prev = done;
    end
  end

  task automatic push_ops(input int n);
    for (int i = 0; i < n; i++) exp_ops.push_back(i);
  endtask

  task automatic push_st(input int p, input int e, input int f, input int t, input int s);
    status_t st;
    st = '{p, e, f, t, s};
    exp_st.push_back(st);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_valid"}, int'(in_valid), 0);
    check({tag, "_in_data"}, int'(in_data), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
    check({tag, "_first_err_op"}, int'(first_err_op), 0);
    check({tag, "_timeout_seen"}, int'(timeout_seen), 0);
    check({tag, "_spurious_cnt"}, int'(spurious_cnt), 0);
  endtask

  // Starts a sweep and waits for done; optionally re-pulses start or asserts
  // reset once the given operand has been requested.
  task automatic run_sweep(input int restart_op, input int reset_op);
    int n;
    bit restarted;
    n = 0;
    restarted = 1'b0;
    last_req_op = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (reset_op >= 0 && last_req_op == reset_op) begin
        reset = 1'b1;
        return;
      end
      if (restart_op >= 0 && last_req_op == restart_op && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
    end
    if (!done) check("sweep_done_within_budget", int'(done), 1);
    @(negedge clk);
    #1;
  endtask

  initial begin : main
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Clean sweep
    push_ops(8);
    push_st(1, 0, 0, 0, 0);
    run_sweep(-1, -1);
    check("clean_busy_after_done", int'(busy), 0);

    // Wrong result for op 5
    bad_op = 5;
    bad_val = 119;
    push_ops(8);
    push_st(0, 1, 5, 0, 0);
    run_sweep(-1, -1);
    bad_op = -1;

    // Engine busy for 10 cycles before op 2
    busy_op = 2;
    busy_len = 10;
    push_ops(8);
    push_st(1, 0, 0, 0, 0);
    run_sweep(-1, -1);
    busy_op = -1;

    // No answer for op 3
    drop_op = 3;
    push_ops(8);
    push_st(0, 1, 3, 1, 0);
    run_sweep(-1, -1);
    check("timeout_gap_op3_op4", req_cyc[4] - req_cyc[3], Tmo + 1);
    drop_op = -1;

    // Reset while waiting on op 4; the late answer must not raise an error
    push_ops(5);
    run_sweep(-1, 4);
    @(posedge clk);
    #1 reset = 1'b0;
    check_all_zero("midrst");
    repeat (4) @(posedge clk);
    #1;
    check("late_resp_err_count", int'(err_count), 0);
    check("late_resp_done", int'(done), 0);
    check("late_resp_busy", int'(busy), 0);
    push_ops(8);
    push_st(1, 0, 0, 0, 0);
    run_sweep(-1, -1);

    // Start mid-sweep plus a stray strobe while stalled in ISSUE
    busy_op = 2;
    busy_len = 10;
    spur_at = 5;
    push_ops(8);
    push_st(0, 0, 0, 0, 1);
    run_sweep(4, -1);
    busy_op = -1;
    spur_at = -1;

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
